count_seq_monitor: RTL and testbench

//   Downstream consumer of the 2-bit free-running up-counter output. Samples the count
//   on a strobe and checks that each sample is previous+1 (mod 4). Reports lock status,

---
 rtl/count_seq_monitor.sv | 149 ++++++++++++++
 tb/tb_count_seq_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
//   Self-check stage behind a 2-bit free-running up-counter. The count is sampled
//   whenever the strobe is high, and each sample is checked to be the previous
//   reference plus one (mod 4). After LOCK_N consecutive correct steps the monitor
//   locks. While locked, it counts sequence errors and completed 3->0 wraps.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (highest priority)
//   c          count value from the upstream counter
//   en         sample strobe; c is examined only when en=1
//   clr        synchronous clear of err, err_cnt, wrap_cnt (FSM unaffected)
//   locked     1 while the FSM is in the locked state
//   err        sticky flag: a mismatch was seen while locked
//   err_cnt    saturating count of mismatches seen while locked
//   wrap_cnt   saturating count of 3->0 steps seen while locked
//   wrap_pulse one-cycle pulse per counted wrap
//   last_c     most recent reference sample

module count_seq_monitor #(
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned ERR_W      = 8,
    parameter int unsigned WRAP_W     = 8,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        c,
    input  logic              en,
    input  logic              clr,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_pulse,
    output logic [1:0]        last_c
);

    typedef enum logic [1:0] {
        StAcq,
        StSync,
        StLock
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          good_q, good_d;
    logic [1:0]          last_c_q, last_c_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic                wrap_pulse_q, wrap_pulse_d;

    logic [1:0]          next_ref;
    logic                match;
    logic                hold;

    assign next_ref = last_c_q + 2'd1;
    assign match    = (c == next_ref);
    // match and hold are mutually exclusive, so hold needs no match qualifier.
    assign hold     = ALLOW_HOLD && (c == last_c_q);

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        last_c_d     = last_c_q;
        err_d        = err_q;
        err_cnt_d    = err_cnt_q;
        wrap_cnt_d   = wrap_cnt_q;
        wrap_pulse_d = 1'b0;

        if (en) begin
            unique case (state_q)
                StAcq: begin
                    last_c_d = c;
                    good_d   = 4'd0;
                    state_d  = StSync;
                end
                StSync: begin
                    if (match) begin
                        last_c_d = c;
                        good_d   = good_q + 4'd1;
                        if (good_q == 4'(LOCK_N - 1)) begin
                            state_d = StLock;
                        end
                    end else if (!hold) begin
                        last_c_d = c;
                        good_d   = 4'd0;
                    end
                end
                StLock: begin
                    if (match) begin
                        last_c_d = c;
                        if (last_c_q == 2'd3) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_cnt_q != '1) begin
                                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                            end
                        end
                    end else if (!hold) begin
                        err_d    = 1'b1;
                        last_c_d = c;
                        good_d   = 4'd0;
                        state_d  = StSync;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: state_d = StAcq;
            endcase
        end

        // Clear wins over a same-cycle error/wrap event; FSM effects above still apply.
        if (clr) begin
            err_d        = 1'b0;
            err_cnt_d    = '0;
            wrap_cnt_d   = '0;
            wrap_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StAcq;
            good_q       <= 4'd0;
            last_c_q     <= 2'd0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            wrap_cnt_q   <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            last_c_q     <= last_c_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign locked     = (state_q == StLock);
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign wrap_pulse = wrap_pulse_q;
    assign last_c     = last_c_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Testbench for count_seq_monitor. Instance a uses default parameters; instance b
// (ALLOW_HOLD=0, ERR_W=2) shares the stimulus and is checked only in the later
// segments. Each step pushes its hand-computed expectation into a queue; a
// separate monitor pops one entry per clock and compares it against the outputs.

module tb_count_seq_monitor;

    logic       clk;
    logic       reset;
    logic [1:0] c;
    logic       en;
    logic       clr;

    logic       a_locked, a_err, a_wrap_pulse;
    logic [7:0] a_err_cnt, a_wrap_cnt;
    logic [1:0] a_last_c;

    logic       b_locked, b_err, b_wrap_pulse;
    logic [1:0] b_err_cnt;
    logic [7:0] b_wrap_cnt;
    logic [1:0] b_last_c;

    count_seq_monitor u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .c          (c),
        .en         (en),
        .clr        (clr),
        .locked     (a_locked),
        .err        (a_err),
        .err_cnt    (a_err_cnt),
        .wrap_cnt   (a_wrap_cnt),
        .wrap_pulse (a_wrap_pulse),
        .last_c     (a_last_c)
    );

    count_seq_monitor #(
        .LOCK_N     (4),
        .ERR_W      (2),
        .WRAP_W     (8),
        .ALLOW_HOLD (1'b0)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .c          (c),
        .en         (en),
        .clr        (clr),
        .locked     (b_locked),
        .err        (b_err),
        .err_cnt    (b_err_cnt),
        .wrap_cnt   (b_wrap_cnt),
        .wrap_pulse (b_wrap_pulse),
        .last_c     (b_last_c)
    );

    typedef struct {
        int         stepn;
        logic       l;
        logic       e;
        logic [7:0] ec;
        logic [7:0] wc;
        logic       wp;
        logic [1:0] lc;
        bit         bchk;
        logic       bl;
        logic [1:0] bec;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int sn, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step %0d %s: got %0h expected %0h", sn, nm, act, req);
        end
    endtask

    // Monitor: outputs are registered, so one entry is consumed per clock.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("a_locked",     x.stepn, 32'(a_locked),     32'(x.l));
                chk("a_err",        x.stepn, 32'(a_err),        32'(x.e));
                chk("a_err_cnt",    x.stepn, 32'(a_err_cnt),    32'(x.ec));
                chk("a_wrap_cnt",   x.stepn, 32'(a_wrap_cnt),   32'(x.wc));
                chk("a_wrap_pulse", x.stepn, 32'(a_wrap_pulse), 32'(x.wp));
                chk("a_last_c",     x.stepn, 32'(a_last_c),     32'(x.lc));
                if (x.bchk) begin
                    chk("b_locked",  x.stepn, 32'(b_locked),  32'(x.bl));
                    chk("b_err_cnt", x.stepn, 32'(b_err_cnt), 32'(x.bec));
                end
            end
        end
    end

    task automatic step(input bit r, input bit e_, input logic [1:0] cv, input bit cl,
                        input logic l, input logic er, input int ec, input int wc,
                        input logic wp, input logic [1:0] lc,
                        input bit bchk = 1'b0, input logic bl = 1'b0, input int bec = 0);
        exp_t x;
        @(negedge clk);
        reset = r;
        en    = e_;
        c     = cv;
        clr   = cl;
        step_no++;
        x.stepn = step_no;
        x.l     = l;
        x.e     = er;
        x.ec    = 8'(ec);
        x.wc    = 8'(wc);
        x.wp    = wp;
        x.lc    = lc;
        x.bchk  = bchk;
        x.bl    = bl;
        x.bec   = 2'(bec);
        exp_q.push_back(x);
    endtask

    // Sample with en=0: c is random noise and every output must hold.
    task automatic idle(input logic l, input logic er, input int ec, input int wc,
                        input logic [1:0] lc, input bit bchk, input logic bl,
                        input int bec);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'($urandom_range(0, 3)), 0, l, er, ec, wc, 0, lc, bchk, bl, bec);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        c     = 2'd0;
        clr   = 1'b0;

        //   rst en c  clr  L  E  EC WC WP LC
        // Acquire and lock: 0 reference, 1,2,3,0 are four matches.
        step(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0,   0, 0, 0, 0, 0, 1);
        step(0, 1, 2, 0,   0, 0, 0, 0, 0, 2);
        step(0, 1, 3, 0,   0, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0,   1, 0, 0, 0, 0, 1);
        step(0, 1, 2, 0,   1, 0, 0, 0, 0, 2);
        step(0, 1, 3, 0,   1, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0,   1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        // Locked mismatch 1 -> 3, then relock after 0,1,2,3.
        step(0, 1, 1, 0,   1, 0, 0, 1, 0, 1);
        step(0, 1, 3, 0,   0, 1, 1, 1, 0, 3);
        step(0, 1, 0, 0,   0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0,   0, 1, 1, 1, 0, 1);
        step(0, 1, 2, 0,   0, 1, 1, 1, 0, 2);
        step(0, 1, 3, 0,   1, 1, 1, 1, 0, 3);
        // Hold accepted while locked.
        step(0, 1, 0, 0,   1, 1, 1, 2, 1, 0);
        step(0, 1, 1, 0,   1, 1, 1, 2, 0, 1);
        step(0, 1, 2, 0,   1, 1, 1, 2, 0, 2);
        step(0, 1, 2, 0,   1, 1, 1, 2, 0, 2);
        step(0, 1, 2, 0,   1, 1, 1, 2, 0, 2);
        step(0, 1, 3, 0,   1, 1, 1, 2, 0, 3);
        // clr together with a locked mismatch: counters clear, lock still drops.
        step(0, 1, 1, 1,   0, 0, 0, 0, 0, 1);
        step(0, 1, 2, 0,   0, 0, 0, 0, 0, 2);
        step(0, 1, 3, 0,   0, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0,   1, 0, 0, 0, 0, 1);
        step(0, 1, 2, 0,   1, 0, 0, 0, 0, 2);
        step(0, 1, 3, 0,   1, 0, 0, 0, 0, 3);
        // clr together with a wrap: no count, no pulse.
        step(0, 1, 0, 1,   1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0,   1, 0, 0, 0, 0, 1);
        step(0, 1, 2, 0,   1, 0, 0, 0, 0, 2);
        step(0, 1, 3, 0,   1, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0,   1, 0, 0, 1, 1, 0);
        step(0, 1, 1, 0,   1, 0, 0, 1, 0, 1);
        step(0, 1, 2, 0,   1, 0, 0, 1, 0, 2);
        step(0, 1, 3, 0,   1, 0, 0, 1, 0, 3);
        step(0, 1, 0, 0,   1, 0, 0, 2, 1, 0);
        // Build locked, err=1, wrap_cnt=2; unlocked 3->0 at the relock is not counted.
        step(0, 1, 2, 0,   0, 1, 1, 2, 0, 2);
        step(0, 1, 3, 0,   0, 1, 1, 2, 0, 3);
        step(0, 1, 0, 0,   0, 1, 1, 2, 0, 0);
        step(0, 1, 1, 0,   0, 1, 1, 2, 0, 1);
        step(0, 1, 2, 0,   1, 1, 1, 2, 0, 2);
        // Mid-operation reset, then a fresh reference.
        step(1, 1, 3, 0,   0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 0,   0, 0, 0, 0, 0, 2);
        step(0, 1, 3, 0,   0, 0, 0, 0, 0, 3);
        idle(0, 0, 0, 0, 3, 0, 0, 0);

        // From here instance b is checked too:     bchk BL BEC
        step(1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 0);
        step(0, 1, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 0);
        step(0, 1, 1, 0,   0, 0, 0, 0, 0, 1,   1, 0, 0);
        step(0, 1, 2, 0,   0, 0, 0, 0, 0, 2,   1, 0, 0);
        step(0, 1, 3, 0,   0, 0, 0, 0, 0, 3,   1, 0, 0);
        step(0, 1, 0, 0,   1, 0, 0, 0, 0, 0,   1, 1, 0);
        step(0, 1, 1, 0,   1, 0, 0, 0, 0, 1,   1, 1, 0);
        step(0, 1, 2, 0,   1, 0, 0, 0, 0, 2,   1, 1, 0);
        // Repeated 2: accepted by a, an error for b.
        step(0, 1, 2, 0,   1, 0, 0, 0, 0, 2,   1, 0, 1);
        step(0, 1, 2, 0,   1, 0, 0, 0, 0, 2,   1, 0, 1);
        step(0, 1, 3, 0,   1, 0, 0, 0, 0, 3,   1, 0, 1);
        step(0, 1, 0, 0,   1, 0, 0, 1, 1, 0,   1, 0, 1);
        step(0, 1, 1, 0,   1, 0, 0, 1, 0, 1,   1, 0, 1);
        step(0, 1, 2, 0,   1, 0, 0, 1, 0, 2,   1, 1, 1);
        // Lock/mismatch cycles drive b's 2-bit err_cnt into saturation.
        step(0, 1, 0, 0,   0, 1, 1, 1, 0, 0,   1, 0, 2);
        step(0, 1, 1, 0,   0, 1, 1, 1, 0, 1,   1, 0, 2);
        step(0, 1, 2, 0,   0, 1, 1, 1, 0, 2,   1, 0, 2);
        step(0, 1, 3, 0,   0, 1, 1, 1, 0, 3,   1, 0, 2);
        step(0, 1, 0, 0,   1, 1, 1, 1, 0, 0,   1, 1, 2);
        step(0, 1, 2, 0,   0, 1, 2, 1, 0, 2,   1, 0, 3);
        step(0, 1, 3, 0,   0, 1, 2, 1, 0, 3,   1, 0, 3);
        step(0, 1, 0, 0,   0, 1, 2, 1, 0, 0,   1, 0, 3);
        step(0, 1, 1, 0,   0, 1, 2, 1, 0, 1,   1, 0, 3);
        step(0, 1, 2, 0,   1, 1, 2, 1, 0, 2,   1, 1, 3);
        step(0, 1, 0, 0,   0, 1, 3, 1, 0, 0,   1, 0, 3);
        step(0, 1, 1, 0,   0, 1, 3, 1, 0, 1,   1, 0, 3);
        step(0, 1, 2, 0,   0, 1, 3, 1, 0, 2,   1, 0, 3);
        step(0, 1, 3, 0,   0, 1, 3, 1, 0, 3,   1, 0, 3);
        step(0, 1, 0, 0,   1, 1, 3, 1, 0, 0,   1, 1, 3);
        step(0, 1, 2, 0,   0, 1, 4, 1, 0, 2,   1, 0, 3);
        idle(0, 1, 4, 1, 2, 1, 0, 3);

        // Drain: the monitor should empty the queue within a few cycles.
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
